// File: rtl/led_seq_ctl_if.sv
// Bus bundle for the LED strobe sequencer: configuration, projector trigger and strobe status.
// Optional LED_SEQ_CTL_MISS_CNT_EN adds the saturating miss_cnt status field.
interface led_seq_ctl_if #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 32,
    parameter int SLOT_W = 4
);
    logic [SLOT_W-1:0]   LedNum;
    logic [CNT_W-1:0]    LedDly;
    logic [CNT_W-1:0]    LedExp;
    logic [4*NUM_CH-1:0] LedSeq;
    logic                seq_rst;
    logic                PROJ_TRG;
    logic [NUM_CH-1:0]   trig;
    logic                busy;
    logic [SLOT_W-1:0]   cur_slot;
    logic                miss;
`ifdef LED_SEQ_CTL_MISS_CNT_EN
    logic [15:0]         miss_cnt;

    modport master (
        output LedNum, LedDly, LedExp, LedSeq, seq_rst, PROJ_TRG,
        input  trig, busy, cur_slot, miss, miss_cnt
    );
    modport slave (
        input  LedNum, LedDly, LedExp, LedSeq, seq_rst, PROJ_TRG,
        output trig, busy, cur_slot, miss, miss_cnt
    );
`else
    modport master (
        output LedNum, LedDly, LedExp, LedSeq, seq_rst, PROJ_TRG,
        input  trig, busy, cur_slot, miss
    );
    modport slave (
        input  LedNum, LedDly, LedExp, LedSeq, seq_rst, PROJ_TRG,
        output trig, busy, cur_slot, miss
    );
`endif
endinterface

// File: rtl/led_seq_ctl.sv
// Projector-synchronised LED strobe sequencer: each trigger rise fires the next slot after a delay.
// Optional feature macro: LED_SEQ_CTL_MISS_CNT_EN (saturating 16-bit dropped-trigger counter).
module led_seq_ctl #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 32,
    parameter int SLOT_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    led_seq_ctl_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_EXPOSE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
    localparam logic [SLOT_W-1:0] SLOT_ZERO = {SLOT_W{1'b0}};
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1'b1);
    localparam logic [SLOT_W-1:0] SLOT_MAX  = SLOT_W'(NUM_CH);
    localparam logic [NUM_CH-1:0] LIT_OFF   = {NUM_CH{1'b0}};

    logic [1:0]        state_q, state_d;
    logic              trg_q, trg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  exp_q, exp_d;
    logic [SLOT_W-1:0] num_q, num_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [NUM_CH-1:0] lit_q, lit_d;
    logic              pend_q, pend_d;
    logic              miss_q, miss_d;

    logic              rise_s;
    logic [SLOT_W-1:0] num_clamp_s;
    logic [SLOT_W:0]   slot_inc_s;
    logic [SLOT_W-1:0] adv_slot_s;
    logic [SLOT_W-1:0] fire_s;
    logic [NUM_CH-1:0] lit_fire_s;
    logic [NUM_CH-1:0] trig_s;

    assign rise_s = bus.PROJ_TRG & ~trg_q;

    // Effective slot count, next slot after this frame, and the one-hot pattern to light.
    always_comb begin
        if (bus.LedNum == SLOT_ZERO) begin
            num_clamp_s = SLOT_ONE;
        end else if (bus.LedNum > SLOT_MAX) begin
            num_clamp_s = SLOT_MAX;
        end else begin
            num_clamp_s = bus.LedNum;
        end
        slot_inc_s = {1'b0, slot_q} + {1'b0, SLOT_ONE};
        if (bus.seq_rst | pend_q) begin
            adv_slot_s = SLOT_ZERO;
        end else if (slot_inc_s >= {1'b0, num_q}) begin
            adv_slot_s = SLOT_ZERO;
        end else begin
            adv_slot_s = slot_inc_s[SLOT_W-1:0];
        end
        // A slot left out of range by a shrunken LedNum falls back to slot 0.
        fire_s = (slot_q >= num_q) ? SLOT_ZERO : slot_q;
        for (int i = 0; i < NUM_CH; i++) begin
            lit_fire_s[i] = (fire_s == SLOT_W'(i));
        end
    end

    // Frame sequencing: delay, exposure (timed or trigger-following), then wait for trigger low.
    always_comb begin
        state_d = state_q;
        trg_d   = bus.PROJ_TRG;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        num_d   = num_q;
        slot_d  = slot_q;
        lit_d   = lit_q;
        pend_d  = pend_q | bus.seq_rst;
        miss_d  = (state_q != ST_IDLE) & rise_s;
        case (state_q)
            ST_IDLE: begin
                pend_d = 1'b0;
                slot_d = (bus.seq_rst | pend_q) ? SLOT_ZERO : slot_q;
                if (rise_s) begin
                    num_d   = num_clamp_s;
                    cnt_d   = bus.LedDly;
                    exp_d   = bus.LedExp;
                    state_d = ST_DELAY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DELAY: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    lit_d   = lit_fire_s;
                    cnt_d   = exp_q;
                    state_d = ST_EXPOSE;
                end
            end
            ST_EXPOSE: begin
                if (exp_q == CNT_ZERO) begin
                    if (!bus.PROJ_TRG) begin
                        lit_d   = LIT_OFF;
                        slot_d  = adv_slot_s;
                        pend_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_EXPOSE;
                    end
                end else if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    lit_d   = LIT_OFF;
                    slot_d  = adv_slot_s;
                    pend_d  = 1'b0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                state_d = bus.PROJ_TRG ? ST_HOLD : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                lit_d   = LIT_OFF;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            trg_q   <= 1'b0;
            cnt_q   <= CNT_ZERO;
            exp_q   <= CNT_ZERO;
            num_q   <= SLOT_ZERO;
            slot_q  <= SLOT_ZERO;
            lit_q   <= LIT_OFF;
            pend_q  <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            trg_q   <= trg_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            num_q   <= num_d;
            slot_q  <= slot_d;
            lit_q   <= lit_d;
            pend_q  <= pend_d;
            miss_q  <= miss_d;
        end
    end

    // Routing: each pin follows the logical slot its code names; bad codes fall back to slot 0.
    always_comb begin
        for (int p = 0; p < NUM_CH; p++) begin
            logic [3:0] code;
            logic       pick;
            code = bus.LedSeq[4*p +: 4];
            pick = lit_q[0];
            for (int j = 0; j < NUM_CH; j++) begin
                pick = (code == 4'(j + 1)) ? lit_q[j] : pick;
            end
            trig_s[p] = ~pick;
        end
    end

`ifdef LED_SEQ_CTL_MISS_CNT_EN
    logic [15:0] miss_cnt_q, miss_cnt_d;

    // Saturating miss counter; seq_rst wins over a coincident miss.
    always_comb begin
        if (bus.seq_rst) begin
            miss_cnt_d = 16'h0000;
        end else if (miss_d && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_d = miss_cnt_q + 16'h0001;
        end else begin
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Miss counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            miss_cnt_q <= 16'h0000;
        end else begin
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.miss_cnt = miss_cnt_q;
`endif

    assign bus.trig     = trig_s;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.cur_slot = slot_q;
    assign bus.miss     = miss_q;
endmodule
